// File: rtl/oled_pkg.sv
// Shared types for the OLED SPI byte transmitter: FSM states and the queued {dc,data} entry.
// No logic here; one tagged byte per FIFO entry.
package oled_pkg;

    localparam int SPI_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        DCGAP,
        HOLD
    } spi_state_t;

    typedef struct packed {
        logic                dc;
        logic [SPI_BITS-1:0] data;
    } spi_entry_t;

    localparam int ENTRY_W = $bits(spi_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, count-based full/empty; rd_dat valid whenever !empty.
// Push ignored when full and pop ignored when empty; no pass-through.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oled_spi_tx.sv
// Buffered SPI mode-3 byte transmitter for the PMOD OLED; MSB first, CS and D/C handled automatically.
// Frame starts one clk after the FIFO goes non-empty; in_ready = !full, so upstream stalls only when the FIFO is full.
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int CLKDIV     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    input  logic                          in_dc,
    output logic                          spi_cs_n,
    output logic                          spi_sclk,
    output logic                          spi_sdin,
    output logic                          spi_dc,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam logic [2:0] BIT_LAST = 3'(SPI_BITS - 1);

    spi_state_t state, state_nxt;
    spi_entry_t fifo_wr, fifo_rd;
    logic       fifo_full, fifo_empty, pop, next_bit, phase_done;
    logic [7:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    assign fifo_wr    = '{dc: in_dc, data: in_data};
    assign in_ready   = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign phase_done = (phase == 8'(CLKDIV - 1));

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (in_valid),
        .pop    (pop),
        .wr_dat (fifo_wr),
        .rd_dat (fifo_rd),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (level)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop       = 1'b1;
                state_nxt = SETUP;
            end
            SETUP:    if (phase_done) state_nxt = SHIFT_LO;
            SHIFT_LO: if (phase_done) state_nxt = SHIFT_HI;
            SHIFT_HI: if (phase_done) begin
                if (bit_cnt != 3'd0) begin
                    state_nxt = SHIFT_LO;
                end else if (!fifo_empty) begin
                    // Back-to-back byte: only a D/C change costs a gap cycle.
                    pop       = 1'b1;
                    state_nxt = (fifo_rd.dc == spi_dc) ? SHIFT_LO : DCGAP;
                end else begin
                    state_nxt = HOLD;
                end
            end
            DCGAP:    if (phase_done) state_nxt = SHIFT_LO;
            HOLD:     if (phase_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Bit presented on entry to SHIFT_LO: a freshly popped byte, the bit after a shift, or the loaded MSB.
    always_comb begin
        next_bit = shreg[7];
        if (pop)                    next_bit = fifo_rd.data[7];
        else if (state == SHIFT_HI) next_bit = shreg[6];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b1;
            spi_sdin <= 1'b0;
            spi_dc   <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= (state_nxt != state || state == IDLE) ? 8'd0 : phase + 1'b1;
            if (pop) begin
                shreg   <= fifo_rd.data;
                bit_cnt <= BIT_LAST;
                spi_dc  <= fifo_rd.dc;
            end else if (state == SHIFT_HI && phase_done && bit_cnt != 3'd0) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - 1'b1;
            end
            spi_cs_n <= (state_nxt == IDLE);
            spi_sclk <= (state_nxt != SHIFT_LO);
            if (state_nxt == SHIFT_LO && state != SHIFT_LO) spi_sdin <= next_bit;
            else if (state_nxt == IDLE)                      spi_sdin <= 1'b0;
        end
    end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Randomised bench for oled_spi_tx: a byte-queue model checks decoded SPI bytes, D/C, frame lengths and edge spacing.
// A second instance with CLKDIV=3 checks the slow-clock timing.
module tb_oled_spi_tx;
    localparam int D  = 1;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_dc = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, spi_cs_n, spi_sclk, spi_sdin, spi_dc, busy;
    logic [2:0] level;

    logic       v2 = 1'b0, dc2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic       rdy2, cs2, sclk2, sdin2, spidc2, busy2;
    logic [2:0] level2;

    always #5 clk = ~clk;

    oled_spi_tx #(.CLKDIV(D), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dc(in_dc), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_sdin(spi_sdin), .spi_dc(spi_dc), .busy(busy), .level(level)
    );

    oled_spi_tx #(.CLKDIV(3), .FIFO_DEPTH(FD)) dut3 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
        .in_data(d2), .in_dc(dc2), .spi_cs_n(cs2), .spi_sclk(sclk2),
        .spi_sdin(sdin2), .spi_dc(spidc2), .busy(busy2), .level(level2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Model: bytes in acceptance order; each must reappear on the wire, in order, with its tag.
    logic [8:0] model_q[$];

    // Wire monitor for the CLKDIV=1 instance.
    int cyc = 0, bitn = 0, frame_len = 0, frame_bytes = 0, frame_gaps = 0;
    int cs_fall_cyc = 0, last_rise = 0, last_frame_len = 0, low_total = 0;
    logic prev_sclk = 1'b1, prev_dc = 1'b0, prev_cs = 1'b1, in_frame = 1'b0;
    logic first_byte = 1'b1, byte_dc = 1'b0, last_dc = 1'b0, stall_seen = 1'b0;
    logic [7:0] cur_byte = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            bitn = 0; in_frame = 1'b0; frame_len = 0;
            prev_sclk = 1'b1; prev_dc = 1'b0; prev_cs = 1'b1;
        end else begin
            logic [8:0] exp_e;
            int gap, exp_gap;
            if (!spi_cs_n) low_total++;
            if (!in_ready) stall_seen = 1'b1;
            check_eq("ready_vs_level", {31'd0, in_ready}, {31'd0, level != 3'(FD)});
            if (prev_cs && !spi_cs_n) begin
                in_frame = 1'b1; frame_len = 0; frame_bytes = 0; frame_gaps = 0;
                cs_fall_cyc = cyc; first_byte = 1'b1;
            end
            if (!spi_cs_n) frame_len++;
            if (!prev_cs && spi_cs_n && in_frame) begin
                check_eq("frame_len", frame_len, D * (2 + 16 * frame_bytes + frame_gaps));
                check_eq("frame_byte_aligned", bitn, 0);
                check_eq("busy_at_cs_rise", {31'd0, busy}, {31'd0, level != 3'd0});
                last_frame_len = frame_len;
                in_frame = 1'b0;
            end
            if (spi_dc != prev_dc)
                check_eq("dc_edge_ok", {30'd0, spi_sclk, bitn == 0}, 32'd3);
            if (!prev_sclk && spi_sclk) begin
                check_eq("rise_in_cs", {31'd0, spi_cs_n}, 32'd0);
                gap     = first_byte && bitn == 0 ? cyc - cs_fall_cyc : cyc - last_rise;
                exp_gap = (bitn == 0 && !first_byte && spi_dc != last_dc) ? 3 * D : 2 * D;
                check_eq("rise_spacing", gap, exp_gap);
                last_rise = cyc;
                if (bitn == 0) byte_dc = spi_dc;
                else check_eq("dc_stable", {31'd0, spi_dc}, {31'd0, byte_dc});
                cur_byte = {cur_byte[6:0], spi_sdin};
                bitn++;
                if (bitn == 8) begin
                    bitn = 0;
                    check_eq("byte_expected", model_q.size() > 0, 1);
                    if (model_q.size() > 0) begin
                        exp_e = model_q.pop_front();
                        check_eq("byte_data", cur_byte, exp_e[7:0]);
                        check_eq("byte_dc", {31'd0, byte_dc}, {31'd0, exp_e[8]});
                    end
                    if (!first_byte && byte_dc != last_dc) frame_gaps++;
                    frame_bytes++;
                    last_dc = byte_dc;
                    first_byte = 1'b0;
                end
            end
            prev_sclk = spi_sclk; prev_dc = spi_dc; prev_cs = spi_cs_n;
        end
    end

    // Monitor for the CLKDIV=3 instance.
    int len2 = 0, lo_run2 = 0, hi_run2 = 0, nrise2 = 0;
    logic p_sclk2 = 1'b1;
    logic [7:0] bits2 = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            if (!cs2) len2++;
            if (!sclk2) lo_run2++;
            else if (!cs2) hi_run2++;
            if (!p_sclk2 && sclk2) begin
                check_eq("d3_lo_half", lo_run2, 3);
                lo_run2 = 0;
                bits2 = {bits2[6:0], sdin2};
                nrise2++;
            end
            if (p_sclk2 && !sclk2) begin
                check_eq("d3_hi_half", hi_run2, 3);
                hi_run2 = 0;
            end
            p_sclk2 = sclk2;
        end
    end

    task automatic push_byte(input logic dc, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_dc = dc;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_ready", {31'd0, in_ready}, 32'd1);
        model_q.push_back({dc, d});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || !spi_cs_n) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", n < 3000, 1);
        repeat (2) @(posedge clk);
        check_eq("model_drained", model_q.size(), 0);
    endtask

    initial begin
        int n;
        int snap;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check_eq("rst_sclk", {31'd0, spi_sclk}, 32'd1);
        check_eq("rst_sdin", {31'd0, spi_sdin}, 32'd0);
        check_eq("rst_dc",   {31'd0, spi_dc},   32'd0);
        check_eq("rst_busy", {31'd0, busy},     32'd0);
        check_eq("rst_level", {29'd0, level},   32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Isolated command byte.
        push_byte(1'b0, 8'hA5);
        wait_idle();
        check_eq("t1_len", last_frame_len, 18);

        // Three data bytes, one frame.
        push_byte(1'b1, 8'h01);
        push_byte(1'b1, 8'h02);
        push_byte(1'b1, 8'h03);
        wait_idle();
        check_eq("t2_len", last_frame_len, 50);

        // D/C change inside a frame costs one gap cycle.
        push_byte(1'b0, 8'hAE);
        push_byte(1'b1, 8'hFF);
        wait_idle();
        check_eq("t3_len", last_frame_len, 35);

        // Fill the FIFO faster than it drains.
        stall_seen = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(1'b1, 8'(8'h10 + i));
        check_eq("t4_stall_seen", {31'd0, stall_seen}, 32'd1);
        wait_idle();

        // Reset in the middle of a byte with more queued.
        push_byte(1'b0, 8'h5A);
        push_byte(1'b0, 8'h11);
        push_byte(1'b0, 8'h22);
        n = 0;
        while (bitn != 4 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check_eq("t5_reached_bit3", bitn, 4);
        #2 reset = 1'b1;
        #1;
        check_eq("t5_cs_n",  {31'd0, spi_cs_n}, 32'd1);
        check_eq("t5_sclk",  {31'd0, spi_sclk}, 32'd1);
        check_eq("t5_level", {29'd0, level},    32'd0);
        check_eq("t5_busy",  {31'd0, busy},     32'd0);
        model_q.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        snap = low_total;
        repeat (80) @(posedge clk);
        check_eq("t5_no_tx_after", low_total - snap, 0);
        check_eq("t5_level_after", {29'd0, level}, 32'd0);

        // Random bursts with random spacing, including arrivals during HOLD.
        for (int it = 0; it < 30; it++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                push_byte(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            repeat ($urandom_range(0, 40)) @(posedge clk);
        end
        wait_idle();

        // Slow clock divider instance.
        @(negedge clk);
        v2 = 1'b1; d2 = 8'h80; dc2 = 1'b1;
        @(posedge clk);
        #1 v2 = 1'b0;
        n = 0;
        @(negedge clk);
        while ((busy2 || !cs2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("d3_idle", n < 500, 1);
        @(negedge clk);
        check_eq("d3_len", len2, 54);
        check_eq("d3_bits", bits2, 8'h80);
        check_eq("d3_nrise", nrise2, 8);
        check_eq("d3_dc", {31'd0, spidc2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
